temp_sampler: RTL and testbench

//  Upstream feeder for the temperature monitor. Samples a binary temperature
//  (unit 0.1 degree) periodically or on demand, saturates it to 999 (99.9),
//  and converts it to 3-digit BCD with a sequential shift-add-3 (double dabble).

---
 rtl/temp_sampler_pkg.sv | 20 ++
 rtl/temp_sampler_dabble_digit.sv | 15 +
 rtl/temp_sampler.sv | 149 ++++++++++++++
 tb/tb_temp_sampler.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/temp_sampler_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : temp_sampler_pkg
//  Description : Shared constants and FSM state codes for the temperature
//                sampler feeding the temperature monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
package temp_sampler_pkg;

    localparam int c_temp_max_tenths = 999;
    localparam int c_bcd_w           = 12;

    typedef logic [1:0] smp_state_t;

    localparam smp_state_t c_smp_idle  = 2'd0;
    localparam smp_state_t c_smp_shift = 2'd1;
    localparam smp_state_t c_smp_done  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/temp_sampler_dabble_digit.sv
`default_nettype none
// ============================================================================
//  Module      : dabble_digit
//  Description : One BCD digit adjust step of double dabble (+3 when >= 5).
//  Revision    : 1.0 - initial release
// ============================================================================
module dabble_digit (
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    assign o_digit = (i_digit >= 4'd5) ? (i_digit + 4'd3) : i_digit;

endmodule
`default_nettype wire

// File: rtl/temp_sampler.sv
`default_nettype none
// ============================================================================
//  Module      : temp_sampler
//  Description : Periodic / on-demand temperature sampler. Saturates to 99.9
//                and converts to 3-digit BCD with a sequential double dabble.
//  Revision    : 1.0 - initial release
// ============================================================================
module temp_sampler
    import temp_sampler_pkg::*;
#(
    parameter int DIV   = 50_000_000,
    parameter int BIN_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [BIN_W-1:0] raw_temp,
    input  logic             sample_now,
    output logic [3:0]       temp_value_huns,
    output logic [3:0]       temp_value_tens,
    output logic [3:0]       temp_value_ones,
    output logic             en,
    output logic             busy,
    output logic             clamped
);

    localparam int c_cnt_w = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int c_sh_w  = $clog2(BIN_W + 1);

    logic [c_cnt_w-1:0] r_period_cnt;
    logic               r_sn_q;
    smp_state_t         r_state;
    smp_state_t         w_state_nxt;
    logic [c_bcd_w-1:0] r_bcd;
    logic [c_bcd_w-1:0] w_bcd_adj;
    logic [BIN_W-1:0]   r_bin;
    logic [BIN_W-1:0]   w_bin_sat;
    logic [c_sh_w-1:0]  r_shift_cnt;
    logic               r_clamp_q;
    logic [3:0]         r_huns;
    logic [3:0]         r_tens;
    logic [3:0]         r_ones;
    logic               r_en;
    logic               r_clamped;
    logic               w_tick;
    logic               w_trig_man;
    logic               w_trigger;
    logic               w_raw_over;
    logic               w_capture;
    logic               w_shift;
    logic               w_publish;

    assign w_tick     = (r_period_cnt == c_cnt_w'(DIV - 1));
    assign w_trig_man = sample_now & ~r_sn_q;
    assign w_trigger  = w_tick | w_trig_man;
    assign w_raw_over = (32'(raw_temp) > 32'(c_temp_max_tenths));
    assign w_bin_sat  = w_raw_over ? BIN_W'(c_temp_max_tenths) : raw_temp;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_period_cnt <= '0;
            r_sn_q       <= 1'b0;
        end else begin
            r_period_cnt <= w_tick ? '0 : (r_period_cnt + c_cnt_w'(1));
            r_sn_q       <= sample_now;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_smp_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The en cycle is still part of busy, so a trigger landing there is dropped.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_smp_idle:  if (w_trigger && !r_en) w_state_nxt = c_smp_shift;
            c_smp_shift: if (r_shift_cnt == c_sh_w'(BIN_W - 1)) w_state_nxt = c_smp_done;
            c_smp_done:  w_state_nxt = c_smp_idle;
            default:     w_state_nxt = c_smp_idle;
        endcase
    end

    always_comb begin
        w_capture = 1'b0;
        w_shift   = 1'b0;
        w_publish = 1'b0;
        case (r_state)
            c_smp_idle:  w_capture = w_trigger && !r_en;
            c_smp_shift: w_shift   = 1'b1;
            c_smp_done:  w_publish = 1'b1;
            default:     w_capture = 1'b0;
        endcase
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_digit
        dabble_digit u_dabble (
            .i_digit (r_bcd[4*gi +: 4]),
            .o_digit (w_bcd_adj[4*gi +: 4])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bcd       <= '0;
            r_bin       <= '0;
            r_shift_cnt <= '0;
            r_clamp_q   <= 1'b0;
        end else if (w_capture) begin
            r_bcd       <= '0;
            r_bin       <= w_bin_sat;
            r_shift_cnt <= '0;
            r_clamp_q   <= w_raw_over;
        end else if (w_shift) begin
            {r_bcd, r_bin} <= {w_bcd_adj, r_bin} << 1;
            r_shift_cnt    <= r_shift_cnt + c_sh_w'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_huns    <= 4'd0;
            r_tens    <= 4'd0;
            r_ones    <= 4'd0;
            r_clamped <= 1'b0;
            r_en      <= 1'b0;
        end else begin
            r_en <= w_publish;
            if (w_publish) begin
                r_huns    <= r_bcd[11:8];
                r_tens    <= r_bcd[7:4];
                r_ones    <= r_bcd[3:0];
                r_clamped <= r_clamp_q;
            end
        end
    end

    assign temp_value_huns = r_huns;
    assign temp_value_tens = r_tens;
    assign temp_value_ones = r_ones;
    assign en              = r_en;
    assign clamped         = r_clamped;
    assign busy            = (r_state != c_smp_idle) || r_en;

endmodule
`default_nettype wire

// File: tb/tb_temp_sampler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_temp_sampler
//  Description : Directed bench with a cycle scoreboard for temp_sampler.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_temp_sampler;

    localparam int DIV   = 20;
    localparam int BIN_W = 10;
    localparam int LAT   = 12;

    logic             clk        = 1'b0;
    logic             rst        = 1'b1;
    logic             sample_now = 1'b0;
    logic [BIN_W-1:0] raw_temp   = '0;
    logic [3:0]       huns;
    logic [3:0]       tens;
    logic [3:0]       ones;
    logic             en;
    logic             busy;
    logic             clamped;

    temp_sampler #(.DIV(DIV), .BIN_W(BIN_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .raw_temp        (raw_temp),
        .sample_now      (sample_now),
        .temp_value_huns (huns),
        .temp_value_tens (tens),
        .temp_value_ones (ones),
        .en              (en),
        .busy            (busy),
        .clamped         (clamped)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         due;
        logic [3:0] h;
        logic [3:0] t;
        logic [3:0] o;
        logic       c;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    int   cyc      = 0;
    int   m_cnt    = 0;
    logic m_sn     = 1'b0;
    int   acc_cyc  = 0;
    bit   have_acc = 1'b0;
    bit   chk_on   = 1'b0;
    bit   ck_busy;
    bit   ck_en;
    bit   ck_trig;
    exp_t ck_e;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk_exp(input int raw, input int due);
        exp_t r;
        int   v;
        v     = (raw > 999) ? 999 : raw;
        r.due = due;
        r.h   = 4'(v / 100);
        r.t   = 4'((v / 10) % 10);
        r.o   = 4'(v % 10);
        r.c   = (raw > 999);
        return r;
    endfunction

    // Reference period counter and edge register, updated on the same edge as the DUT.
    always @(posedge clk) begin
        if (rst) begin
            m_cnt <= 0;
            m_sn  <= 1'b0;
        end else begin
            m_cnt <= (m_cnt == DIV - 1) ? 0 : m_cnt + 1;
            m_sn  <= sample_now;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            cyc++;
            ck_busy = have_acc && (cyc > acc_cyc) && (cyc <= acc_cyc + LAT);
            ck_en   = (sb_q.size() > 0) && (sb_q[0].due == cyc);
            check("sb_en", en, ck_en);
            check("sb_busy", busy, ck_busy);
            if (en && sb_q.size() > 0) begin
                ck_e = sb_q.pop_front();
                check("sb_huns", huns, ck_e.h);
                check("sb_tens", tens, ck_e.t);
                check("sb_ones", ones, ck_e.o);
                check("sb_clamped", clamped, ck_e.c);
            end
            if (rst) begin
                sb_q.delete();
                have_acc = 1'b0;
            end else begin
                ck_trig = (m_cnt == DIV - 1) || (sample_now && !m_sn);
                if (ck_trig && !ck_busy) begin
                    sb_q.push_back(mk_exp(int'(raw_temp), cyc + LAT));
                    acc_cyc  = cyc;
                    have_acc = 1'b1;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cnt(input int target);
        int n;
        n = 0;
        while (m_cnt != target && n < 100) begin
            step();
            n++;
        end
        check("wait_cnt_bound", (n < 100), 1);
    endtask

    task automatic wait_en(input int limit, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!en && lat < limit);
        check("en_seen", en, 1);
    endtask

    task automatic convert(input int raw, input int raw_after, input string tag);
        int   lat;
        exp_t e;
        wait_cnt(12);
        raw_temp   = BIN_W'(raw);
        sample_now = 1'b1;
        step();
        sample_now = 1'b0;
        raw_temp   = BIN_W'(raw_after);
        wait_en(40, lat);
        e = mk_exp(raw, 0);
        check({tag, "_lat"}, lat, LAT);
        check({tag, "_huns"}, huns, e.h);
        check({tag, "_tens"}, tens, e.t);
        check({tag, "_ones"}, ones, e.o);
        check({tag, "_clamped"}, clamped, e.c);
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int n_en;

        rst = 1'b1;
        repeat (3) step();
        check("rst_huns", huns, 0);
        check("rst_tens", tens, 0);
        check("rst_ones", ones, 0);
        check("rst_en", en, 0);
        check("rst_busy", busy, 0);
        check("rst_clamped", clamped, 0);
        chk_on = 1'b1;
        step();
        rst = 1'b0;

        convert(400, 400, "c400");
        convert(1023, 1023, "c1023");
        convert(5, 5, "c5");

        raw_temp = BIN_W'(473);
        wait_en(40, lat);
        check("per1_huns", huns, 4);
        check("per1_tens", tens, 7);
        check("per1_ones", ones, 3);
        for (int i = 0; i < 2; i++) begin
            wait_en(25, lat);
            check("per_gap", lat, DIV);
            check("per_huns", huns, 4);
            check("per_tens", tens, 7);
            check("per_ones", ones, 3);
        end
        step();

        wait_cnt(DIV - 1);
        sample_now = 1'b1;
        n_en = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (en) n_en++;
            step();
            if (i == 0) sample_now = 1'b0;
            if (i == 3) sample_now = 1'b1;
            if (i == 5) sample_now = 1'b0;
        end
        check("coinc_en_count", n_en, 1);

        wait_cnt(12);
        raw_temp   = BIN_W'(888);
        sample_now = 1'b1;
        step();
        sample_now = 1'b0;
        repeat (4) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_en = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (en) n_en++;
        end
        check("abort_en_count", n_en, 0);
        check("abort_huns", huns, 0);
        check("abort_tens", tens, 0);
        check("abort_ones", ones, 0);
        check("abort_busy", busy, 0);
        step();
        convert(250, 250, "post_rst");

        convert(123, 999, "hold");

        repeat (3) step();
        chk_on = 1'b0;
        check("sb_drained", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
